uart_word_serializer: RTL and testbench
=======================================

// Module: uart_word_serializer
// PURPOSE
//  Sits between the debug unit and the UART transmitter. Buffers NB-bit result words
//  (PC, register, memory data, ALU result) in a small FIFO and splits each into
//  NB/DATA_BITS bytes, least-significant byte first. Paces the bytes with a one-cycle
//  start pulse to the transmitter and waits for its done tick before sending the next.
// PARAMETERS
//  NB          32  word width; must be a multiple of DATA_BITS
//  DATA_BITS    8  UART byte width
//  FIFO_DEPTH   4  word FIFO depth; power of 2, >= 2
// PORTS
//  i_clk           in   1             system clock
//  i_reset         in   1             asynchronous, active-low reset
//  i_word_valid    in   1             word offered by debug unit
//  i_word_data     in   NB            word to transmit
//  o_word_ready    out  1             FIFO can accept a word (= !full)
//  i_tx_done       in   1             transmitter byte-complete tick, 1 cycle
//  o_tx_start      out  1             start pulse to transmitter, 1 cycle
//  o_tx_data       out  DATA_BITS     byte to transmit
//  o_busy          out  1             FIFO not empty OR FSM not IDLE
//  o_fifo_count    out  clog2(D+1)    words currently stored
//  o_overflow      out  1             sticky: valid seen while !ready
// BEHAVIOUR
//  Reset (i_reset=0, async): FIFO empty, pointers 0, FSM=IDLE, byte index 0, shift reg 0;
//   o_tx_start=0, o_tx_data=0, o_busy=0, o_fifo_count=0, o_overflow=0, o_word_ready=1.
//   Reset asserted mid-word aborts it immediately; partially sent word is lost.
//  Push: i_word_valid & o_word_ready on a rising edge writes i_word_data. o_word_ready
//   depends only on full; no pass-through when full, even if a pop occurs in the same cycle.
//   Simultaneous push and pop: count unchanged, both pointers advance.
//  Pointers: wrap modulo FIFO_DEPTH; full/empty come from o_fifo_count (0..FIFO_DEPTH).
//  FSM states:
//   IDLE : if FIFO not empty, pop the head into the shift reg, idx<=0, go to SEND.
//   SEND : o_tx_start=1 for exactly this cycle; o_tx_data=shift[DATA_BITS-1:0]; go to WAIT.
//   WAIT : on i_tx_done: if idx==NB/DATA_BITS-1, go to IDLE; else shift right by
//          DATA_BITS, idx++, go to SEND. Otherwise stay in WAIT.
//  o_tx_data is registered and stays stable from SEND until the next SEND or reset.
//  i_tx_done outside WAIT is ignored. No timeout in WAIT.
//  Latency: word pushed into an empty FIFO at edge N -> popped at N+1 -> o_tx_start high
//   in the cycle after edge N+2. Between words there is one IDLE cycle (no back-to-back pop).
//  o_overflow: set when i_word_valid & !o_word_ready; cleared only by reset.
//  o_busy is combinational from count and state.
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE/SEND/WAIT, 2-bit), DATA_BITS default,
//   BYTES_PER_WORD = NB/DATA_BITS helper.
//  Sub-module sync_fifo (WIDTH=NB, DEPTH=FIFO_DEPTH; push/pop/full/empty/count).
//   Reused later for RX buffering.
//  Top level holds the FSM, shift register, byte index and overflow flag.
// TESTING
//  1 Reset, push 0x12345678, pulse i_tx_done 5 cycles after each start -> bytes
//    78,56,34,12 in order, 4 start pulses, then o_busy=0.
//  2 Push 5 words back-to-back with done held off -> ready drops after the 4th (count=4)
//    while the 1st is in the shift reg; 5th accepted once popped; o_overflow stays 0
//    (valid held until ready).
//  3 Force valid while full -> o_overflow=1, sticky until reset; FIFO contents unchanged.
//  4 Spurious i_tx_done in IDLE/SEND -> no state change, no extra byte emitted.
//  5 Assert i_reset after the 2nd byte of 0xAABBCCDD -> all outputs at reset values
//    immediately; after release, pushing 0x00000001 emits 01,00,00,00.
//  6 Push and pop in the same cycle at count=2 -> count stays 2; pointer wrap over
//    10 words shows FIFO order preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared FSM encodings and sizing helpers for the UART word path.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    function automatic int bytes_per_word(input int nb, input int data_bits);
        return nb / data_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module : sync_fifo
//  Brief  : Single-clock FIFO with occupancy count; full/empty derive from count.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // A push is refused whenever full, even if a pop frees a slot this cycle.
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_word_serializer.sv
// ============================================================================
//  Module : uart_word_serializer
//  Brief  : Buffers result words and feeds them LSB-first, byte by byte, to a UART.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_word_serializer
    import uart_pkg::*;
#(
    parameter int NB         = 32,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_word_valid,
    input  logic [NB-1:0]                   i_word_data,
    output logic                            o_word_ready,
    input  logic                            i_tx_done,
    output logic                            o_tx_start,
    output logic [DATA_BITS-1:0]            o_tx_data,
    output logic                            o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fifo_count,
    output logic                            o_overflow
);

    localparam int BPW = bytes_per_word(NB, DATA_BITS);
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [1:0]           r_state;
    logic [NB-1:0]        r_shift;
    logic [IW-1:0]        r_idx;
    logic                 r_tx_start;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_overflow;

    logic [NB-1:0]        w_fifo_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic [CW-1:0]        w_count;

    // Pops only from IDLE, which guarantees one idle cycle between words.
    assign w_pop = (r_state == ST_IDLE) & ~w_empty;

    sync_fifo #(
        .WIDTH (NB),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_word_valid),
        .i_wdata (i_word_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_overflow <= r_overflow | (i_word_valid & w_full);
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_fifo_rdata;
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_shift[DATA_BITS-1:0];
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (r_idx == IW'(BPW - 1)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_shift <= r_shift >> DATA_BITS;
                            r_idx   <= r_idx + IW'(1);
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_word_ready = ~w_full;
    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_busy       = ~w_empty | (r_state != ST_IDLE);
    assign o_fifo_count = w_count;
    assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_serializer.sv
// ============================================================================
//  Module : tb_uart_word_serializer
//  Brief  : Scoreboard bench: issued words queue expected bytes; a monitor checks starts.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_word_serializer;

    logic        clk;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        done_auto;
    logic        done_man;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        overflow;

    logic [7:0]  exp_q[$];
    int          n_pass;
    int          n_total;
    int          n_starts;
    logic        auto_en;
    logic        resp_busy;

    assign tx_done = done_auto | done_man;

    uart_word_serializer #(
        .NB         (32),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_word_valid (word_valid),
        .i_word_data  (word_data),
        .o_word_ready (word_ready),
        .i_tx_done    (tx_done),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every start pulse must match the head of the expected-byte queue.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                n_starts++;
                if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Transmitter model: answers each start with a done tick a few cycles later.
    initial begin
        done_auto = 1'b0;
        resp_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1 && auto_en) begin
                resp_busy = 1'b1;
                repeat (4) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation timeout");
    end

    task automatic push_word(input logic [31:0] d);
        int t;
        t = 0;
        word_valid = 1'b1;
        word_data  = d;
        while (!word_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!word_ready) begin
            chk("push_timeout", 32'd0, 32'd1);
            word_valid = 1'b0;
            return;
        end
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !resp_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_idle", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (!tx_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("start_seen", {31'd0, tx_start}, 32'd1);
    endtask

    task automatic pulse_done_man();
        done_man = 1'b1;
        @(negedge clk);
        done_man = 1'b0;
    endtask

    initial begin
        int s0;
        int cnt;
        int t;
        n_pass = 0; n_total = 0; n_starts = 0;
        rst_n = 1'b0; word_valid = 1'b0; word_data = '0;
        done_man = 1'b0; auto_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_ready", {31'd0, word_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // 1: single word, latency and byte order
        s0 = n_starts;
        push_word(32'h12345678);
        chk("busy_after_push", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("lat_no_start_early", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("lat_start", {31'd0, tx_start}, 32'd1);
        wait_idle();
        chk("t1_starts", n_starts - s0, 32'd4);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2: five words with done held off; handshake keeps overflow clear
        auto_en = 1'b0;
        push_word(32'hA0A1A2A3);
        push_word(32'hB0B1B2B3);
        push_word(32'hC0C1C2C3);
        push_word(32'hD0D1D2D3);
        push_word(32'hE0E1E2E3);
        chk("t2_count_full", {29'd0, fifo_count}, 32'd4);
        chk("t2_ready_low", {31'd0, word_ready}, 32'd0);
        chk("t2_ovf_clear", {31'd0, overflow}, 32'd0);

        // 3: forced valid while full sets sticky overflow, word dropped
        word_valid = 1'b1;
        word_data  = 32'hDEADBEEF;
        @(negedge clk);
        word_valid = 1'b0;
        chk("t3_ovf_set", {31'd0, overflow}, 32'd1);
        chk("t3_count", {29'd0, fifo_count}, 32'd4);
        pulse_done_man();
        auto_en = 1'b1;
        wait_idle();
        chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("t3_count_empty", {29'd0, fifo_count}, 32'd0);

        // 4: spurious done in IDLE and in SEND
        s0 = n_starts;
        pulse_done_man();
        repeat (10) @(negedge clk);
        chk("t4_idle_starts", n_starts - s0, 32'd0);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        push_word(32'h0F1E2D3C);
        @(negedge clk);
        pulse_done_man();
        wait_idle();
        chk("t4_send_starts", n_starts - s0, 32'd4);

        // 5: reset after the second byte
        push_word(32'hAABBCCDD);
        cnt = 0; t = 0;
        while (cnt < 2 && t < 500) begin
            @(negedge clk);
            if (tx_start) cnt++;
            t++;
        end
        chk("t5_two_bytes", cnt, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_start", {31'd0, tx_start}, 32'd0);
        chk("t5_rst_data", {24'd0, tx_data}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("t5_rst_ready", {31'd0, word_ready}, 32'd1);
        chk("t5_left_bytes", exp_q.size(), 32'd2);
        exp_q.delete();
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_word(32'h00000001);
        wait_idle();

        // 6: simultaneous push and pop at count=2
        auto_en = 1'b0;
        push_word(32'h11111111);
        push_word(32'h22222222);
        push_word(32'h33333333);
        chk("t6_count2", {29'd0, fifo_count}, 32'd2);
        for (int b = 0; b < 4; b++) begin
            wait_start();
            pulse_done_man();
        end
        chk("t6_pre_count", {29'd0, fifo_count}, 32'd2);
        word_valid = 1'b1;
        word_data  = 32'h44444444;
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h44);
        chk("t6_pushpop_count", {29'd0, fifo_count}, 32'd2);
        auto_en = 1'b1;
        wait_idle();

        // 6b: pointer wrap over ten words
        for (int w = 0; w < 10; w++) begin
            push_word({4{8'(8'h50 + w)}} ^ 32'h00FF0000);
        end
        wait_idle();
        chk("t6_final_count", {29'd0, fifo_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
